puf_resp_serializer: RTL and testbench
======================================

# puf_resp_serializer

Downstream consumer of the 128-bit PUF response block. It detects the rising edge of `puf_done`, captures `puf_out`, and streams it as a fixed 18-byte frame over a valid/ready byte interface toward the UART/host link. Frame layout: header byte, 16 response bytes (MSB byte first), one XOR checksum byte.

## Interface

- `RESP_W`, 128: response width; fixed at 128, must be a multiple of 8.
- `HDR_BYTE`, 8'hA5: frame header value.
- `clk` in 1: single clock domain, shared with the PUF block.
- `rst` in 1: reset, asynchronous assert, active-low (0 = reset).
- `puf_done` in 1: response-ready level from the PUF block; held high once the response is valid.
- `puf_out` in RESP_W: PUF response; sampled only on the `puf_done` rising edge.
- `tx_data` out 8: current frame byte.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: sink accepts a byte when `tx_valid && tx_ready` at a `posedge clk`.
- `busy` out 1: frame in progress (capture through last transfer).
- `frame_done` out 1: one-cycle pulse after the checksum byte transfers.
- `overrun` out 1: sticky; a `puf_done` rising edge arrived while `busy`.

## Operation

- Edge detect: register `done_d <= puf_done`. `rise = puf_done & ~done_d`.
- FSM states:
  - IDLE
    - On `rise`: capture `puf_out` into `resp_q`, set `idx = 0`, go to HDR.
  - HDR
    - Drive `HDR_BYTE`, `tx_valid = 1`.
    - On handshake, go to DATA.
  - DATA
    - Drive `resp_q[127-8*idx -: 8]`, `tx_valid = 1`.
    - On handshake with `idx == 15`, go to CSUM. Otherwise `idx++`.
  - CSUM
    - Drive `csum_q`, `tx_valid = 1`.
    - On handshake, go to DONE.
  - DONE
    - `frame_done = 1` for one cycle, then go to IDLE.
- `idx` is a 4-bit counter. It is never incremented past 15, so no wrap-around occurs.
- Checksum: `csum_q` = XOR of the 16 bytes of `resp_q`. It is computed combinationally from `puf_out` and registered at capture. The header byte is not included.
- `busy` = state != IDLE (DONE included).
- `rise` in any state other than IDLE is ignored and sets `overrun`. The frame in progress is unaffected, and `resp_q` is not overwritten.
- `rise` in the same cycle that DONE returns to IDLE is also an overrun. A new frame needs the rising edge while in IDLE.
- Only a rising edge starts a frame. A `puf_done` held high produces exactly one frame.
- `overrun` clears only on reset.
- Reset (async, rst=0) values:
  - state IDLE, `done_d` 0, `resp_q` 0, `csum_q` 0, `idx` 0.
  - `tx_valid` 0, `tx_data` 0, `busy` 0, `frame_done` 0, `overrun` 0.
- Reset mid-frame aborts the frame; no partial completion.
- Because `done_d` resets to 0, a `puf_done` still high at reset release counts as a rising edge: the frame is re-sent.

## Timing

- Rising edge of `puf_done` sampled at edge N. At edge N+1 the header is driven: `tx_valid` = 1, `tx_data` = `HDR_BYTE`, `busy` = 1.
- `tx_data` is registered, with no combinational path from `tx_ready` to `tx_data`.
- `tx_valid` and `tx_data` hold stable while `tx_valid && !tx_ready`.
- `tx_valid` never drops without a handshake, except on reset.
- With `tx_ready` tied 1:
  - 18 consecutive transfers at edges N+1 … N+18.
  - `frame_done` high for the cycle after edge N+18.
  - Back in IDLE after edge N+19.
- Back-pressure stretches each byte independently. Byte order and count never change.
- `frame_done` never coincides with `tx_valid`.

## Structure

- Shared package `puf_ser_pkg`, holding:
  - state enum (IDLE, HDR, DATA, CSUM, DONE);
  - `FRAME_LEN` = 18;
  - `HDR_BYTE` default;
  - function `xor_fold8(logic [127:0])` returning 8 bits.
- No sub-module: edge detect, FSM and byte mux are in one module.

## Test plan

- Single frame, no back-pressure:
  - Stimulus: reset, then `puf_done` 0→1 with `puf_out` = 128'h5468697349734E6F74576F726B696E67, `tx_ready` = 1.
  - Response: bytes A5, 54 68 69 73 49 73 4E 6F 74 57 6F 72 6B 69 6E 67, 08 on consecutive cycles. Then one `frame_done` pulse, `busy` = 0 after.
- Back-pressure:
  - Stimulus: same frame, `tx_ready` toggling pseudo-randomly, including 5-cycle low stretches.
  - Response: identical 18-byte sequence; `tx_data` is stable while stalled.
- Held `puf_done`:
  - Stimulus: `puf_done` kept high for 200 cycles.
  - Response: exactly one frame; `overrun` = 0.
- Overrun:
  - Stimulus: during DATA with `tx_ready` = 0, pulse `puf_done` low for 2 cycles, then high with `puf_out` = 0.
  - Response: `overrun` = 1; the frame in progress completes with the original bytes; no second frame.
- Checksum edge values:
  - `puf_out` = 0 → checksum 00.
  - `puf_out` = 128'h…0001 → last data byte 01, checksum 01.
- Reset mid-frame:
  - Stimulus: assert `rst` = 0 after the 7th transfer.
  - Response: outputs go to reset values immediately. On release with `puf_done` still high, a complete new frame starts from header A5.

Source files
------------

// File: rtl/puf_ser_pkg.sv
// Shared types and helpers for the PUF response serializer.
// The frame is one header byte, the response bytes MSB first, then an XOR checksum byte.
package puf_ser_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam int          FRAME_LEN        = 18;
    localparam logic [7:0]  DEFAULT_HDR_BYTE = 8'hA5;

    // XOR of all 16 bytes of a 128-bit response; the header is not part of it.
    function automatic logic [7:0] xor_fold8(input logic [127:0] v);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < 16; i++) begin
            acc = acc ^ v[8*i +: 8];
        end
        return acc;
    endfunction

endpackage

// File: rtl/puf_resp_serializer.sv
// Captures the PUF response on the rising edge of puf_done and streams it as an
// 18-byte valid/ready frame. tx_data is registered; tx_valid decodes the state register.
module puf_resp_serializer
    import puf_ser_pkg::*;
#(
    parameter int         RESP_W   = 128,
    parameter logic [7:0] HDR_BYTE = DEFAULT_HDR_BYTE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              puf_done,
    input  logic [RESP_W-1:0] puf_out,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun
);

    localparam int NBYTES = RESP_W / 8;

    state_t            state_reg, state_next;
    logic              done_d;
    logic [RESP_W-1:0] resp_q, resp_next;
    logic [7:0]        csum_q, csum_next;
    logic [3:0]        idx_reg, idx_next;
    logic              overrun_reg, overrun_next;
    logic [7:0]        tx_data_next;
    logic              rise;
    logic              handshake;
    logic [7:0]        resp_bytes [NBYTES];

    assign rise      = puf_done & ~done_d;
    assign handshake = tx_valid & tx_ready;

    // Byte view of the response as it will be after this edge, MSB byte at index 0.
    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bytes
            assign resp_bytes[gi] = resp_next[RESP_W-1-8*gi -: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            done_d      <= 1'b0;
            resp_q      <= '0;
            csum_q      <= 8'h00;
            idx_reg     <= 4'd0;
            overrun_reg <= 1'b0;
            tx_data     <= 8'h00;
        end else begin
            state_reg   <= state_next;
            done_d      <= puf_done;
            resp_q      <= resp_next;
            csum_q      <= csum_next;
            idx_reg     <= idx_next;
            overrun_reg <= overrun_next;
            tx_data     <= tx_data_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        resp_next    = resp_q;
        csum_next    = csum_q;
        overrun_next = overrun_reg;

        case (state_reg)
            IDLE: begin
                if (rise) begin
                    resp_next  = puf_out;
                    csum_next  = xor_fold8(puf_out);
                    idx_next   = 4'd0;
                    state_next = HDR;
                end
            end
            HDR: begin
                if (handshake) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (handshake) begin
                    if (idx_reg == 4'(NBYTES - 1)) begin
                        state_next = CSUM;
                    end else begin
                        idx_next = idx_reg + 4'd1;
                    end
                end
            end
            CSUM: begin
                if (handshake) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A new edge outside IDLE (DONE included) is dropped but remembered.
        if (rise && state_reg != IDLE) begin
            overrun_next = 1'b1;
        end

        // Byte for the following cycle, so tx_data comes straight from a flop.
        case (state_next)
            HDR:     tx_data_next = HDR_BYTE;
            DATA:    tx_data_next = resp_bytes[idx_next];
            CSUM:    tx_data_next = csum_next;
            default: tx_data_next = 8'h00;
        endcase
    end

    always_comb begin
        tx_valid   = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state_reg)
            HDR, DATA, CSUM: begin
                tx_valid = 1'b1;
                busy     = 1'b1;
            end
            DONE: begin
                busy       = 1'b1;
                frame_done = 1'b1;
            end
            default: begin
                tx_valid   = 1'b0;
            end
        endcase
    end

    assign overrun = overrun_reg;

endmodule

// File: tb/tb_puf_resp_serializer.sv
// Scoreboard bench for puf_resp_serializer: expected frame bytes are queued when a
// capture is triggered and popped on every valid/ready transfer.
module tb_puf_resp_serializer;

    logic         clk;
    logic         rst;
    logic         puf_done;
    logic [127:0] puf_out;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         busy;
    logic         frame_done;
    logic         overrun;

    logic [7:0] exp_q [$];
    int         check_cnt = 0;
    int         pass_cnt  = 0;
    int         xfer_count = 0;
    int         frames = 0;

    localparam logic [127:0] V_TEXT = 128'h5468697349734E6F74576F726B696E67;
    localparam logic [127:0] V_OVR  = 128'h0123456789ABCDEFFEDCBA9876543210;

    puf_resp_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .puf_done   (puf_done),
        .puf_out    (puf_out),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [127:0] v, input logic [7:0] csum);
        logic [127:0] tmp;
        tmp = v;
        exp_q.push_back(8'hA5);
        for (int i = 15; i >= 0; i--) begin
            exp_q.push_back(tmp[8*i +: 8]);
        end
        exp_q.push_back(csum);
    endtask

    // Waits for frame_done, driving tx_ready each cycle (mode 0: always 1, mode 1: stalls).
    task automatic wait_fd(input int mode, input int maxc, output int cycles);
        int found;
        found  = 0;
        cycles = 0;
        while (found == 0 && cycles < maxc) begin
            @(posedge clk);
            #1;
            cycles++;
            if (frame_done) begin
                found = 1;
            end else if (mode == 1) begin
                tx_ready = ((cycles % 13) < 5) ? 1'b0 : 1'($urandom_range(0, 1));
            end else begin
                tx_ready = 1'b1;
            end
        end
        check("fd_seen", found, 1);
    endtask

    task automatic run_frame(input logic [127:0] v, input logic [7:0] csum, input int mode,
                             output int cycles);
        puf_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        push_frame(v, csum);
        puf_out  = v;
        tx_ready = (mode == 0);
        puf_done = 1'b1;
        wait_fd(mode, 600, cycles);
    endtask

    task automatic wait_xfers(input int target, input int maxc);
        int n;
        n = 0;
        while (xfer_count < target && n < maxc) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("xfer_reached", (xfer_count >= target), 1);
    endtask

    // Monitor: scoreboard pop on each transfer, stall stability, frame_done checks.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        logic [7:0] e;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", tx_valid, 1);
                    check("stall_data", tx_data, prev_data);
                end
                if (tx_valid && tx_ready) begin
                    check("sb_nonempty", (exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        $display("xfer %0d data %02h expected %02h", xfer_count, tx_data, e);
                        check("byte", tx_data, e);
                    end
                    xfer_count++;
                end
                if (frame_done) begin
                    frames++;
                    $display("frame %0d done", frames);
                    check("fd_no_valid", tx_valid, 0);
                    check("fd_sb_empty", exp_q.size(), 0);
                end
                prev_stall = tx_valid && !tx_ready;
                prev_data  = tx_data;
            end
        end
    end

    initial begin
        int cyc;
        int f0;
        int s0;
        rst      = 1'b0;
        puf_done = 1'b0;
        puf_out  = '0;
        tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", tx_valid, 0);
        check("rst_data", tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_fd", frame_done, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b1;

        // Single frame, no back-pressure; also covers held puf_done afterwards.
        f0 = frames;
        run_frame(V_TEXT, 8'h08, 0, cyc);
        check("fd_latency", cyc, 19);
        check("fd_busy", busy, 1);
        @(posedge clk);
        #1;
        check("idle_busy", busy, 0);
        check("idle_fd", frame_done, 0);
        repeat (200) @(posedge clk);
        #1;
        check("held_frames", frames - f0, 1);
        check("held_overrun", overrun, 0);
        check("held_busy", busy, 0);

        // Back-pressure with 5-cycle stalls.
        run_frame(V_TEXT, 8'h08, 1, cyc);

        // Checksum edge values.
        run_frame(128'h0, 8'h00, 0, cyc);
        run_frame(128'h1, 8'h01, 0, cyc);
        repeat (3) @(posedge clk);
        #1;
        check("pre_ovr_overrun", overrun, 0);

        // Overrun: new edge arrives while stalled in DATA.
        f0 = frames;
        puf_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        push_frame(V_OVR, 8'h00);
        puf_out  = V_OVR;
        tx_ready = 1'b1;
        puf_done = 1'b1;
        s0 = xfer_count;
        wait_xfers(s0 + 4, 50);
        tx_ready = 1'b0;
        puf_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        puf_out  = '0;
        puf_done = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("ovr_flag", overrun, 1);
        check("ovr_busy", busy, 1);
        wait_fd(0, 100, cyc);
        repeat (30) @(posedge clk);
        #1;
        check("ovr_frames", frames - f0, 1);
        check("ovr_sticky", overrun, 1);

        // Reset after the 7th transfer, then resend on release with puf_done high.
        puf_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        push_frame(V_TEXT, 8'h08);
        puf_out  = V_TEXT;
        tx_ready = 1'b1;
        puf_done = 1'b1;
        s0 = xfer_count;
        wait_xfers(s0 + 7, 50);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", tx_valid, 0);
        check("mid_rst_data", tx_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_overrun", overrun, 0);
        exp_q.delete();
        f0 = frames;
        repeat (3) @(posedge clk);
        #1;
        check("in_rst_fd", frame_done, 0);
        push_frame(V_TEXT, 8'h08);
        rst = 1'b1;
        wait_fd(0, 100, cyc);
        check("resend_latency", cyc, 19);
        repeat (5) @(posedge clk);
        #1;
        check("resend_frames", frames - f0, 1);
        check("final_sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
